// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin between execute and load/store results,
// one register-file write per cycle through a single output stage.
module wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            exu_wb_valid_i,
    output logic            exu_wb_ready_o,
    input  logic [4:0]      exu_wb_addr_i,
    input  logic [XLEN-1:0] exu_wb_data_i,
    input  logic            lsu_wb_valid_i,
    output logic            lsu_wb_ready_o,
    input  logic [4:0]      lsu_wb_addr_i,
    input  logic [XLEN-1:0] lsu_wb_data_i,
    output logic            rd_wr_en_o,
    output logic [4:0]      rd_wr_addr_o,
    output logic [XLEN-1:0] rd_wr_data_o,
    input  logic [4:0]      rs1_rd_addr_i,
    input  logic [4:0]      rs2_rd_addr_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o
);

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_LSU = 1'b1
    } gnt_e;

    gnt_e            last_grant;
    logic            exu_gnt;
    logic            lsu_gnt;
    logic            xfer;
    logic [4:0]      sel_addr;
    logic [XLEN-1:0] sel_data;

    // The requester that lost the previous transfer wins a contention.
    always_comb begin
        exu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (exu_wb_valid_i && lsu_wb_valid_i) begin
            exu_gnt = (last_grant == GNT_LSU);
            lsu_gnt = (last_grant == GNT_EXU);
        end else begin
            exu_gnt = exu_wb_valid_i;
            lsu_gnt = lsu_wb_valid_i;
        end
    end

    assign exu_wb_ready_o = exu_gnt;
    assign lsu_wb_ready_o = lsu_gnt;
    assign xfer           = exu_gnt | lsu_gnt;

    always_comb begin
        sel_addr = exu_wb_addr_i;
        sel_data = exu_wb_data_i;
        if (lsu_gnt) begin
            sel_addr = lsu_wb_addr_i;
            sel_data = lsu_wb_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant <= GNT_LSU;
        end else if (xfer) begin
            last_grant <= lsu_gnt ? GNT_LSU : GNT_EXU;
        end
    end

    // x0 writes are accepted but never reach the register file.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_wr_en_o   <= 1'b0;
            rd_wr_addr_o <= '0;
            rd_wr_data_o <= '0;
        end else if (xfer) begin
            rd_wr_en_o   <= (sel_addr != 5'd0);
            rd_wr_addr_o <= sel_addr;
            rd_wr_data_o <= sel_data;
        end else begin
            rd_wr_en_o   <= 1'b0;
        end
    end

    function automatic logic busy_of(input logic [4:0] rs);
        logic hit;
        hit = 1'b0;
        if (exu_wb_valid_i && (exu_wb_addr_i == rs)) hit = 1'b1;
        if (lsu_wb_valid_i && (lsu_wb_addr_i == rs)) hit = 1'b1;
        if (rd_wr_en_o && (rd_wr_addr_o == rs))      hit = 1'b1;
        return hit && (rs != 5'd0);
    endfunction

    assign rs1_busy_o = busy_of(rs1_rd_addr_i);
    assign rs2_busy_o = busy_of(rs2_rd_addr_i);

endmodule
